// File: rtl/pixel_plot_queue_pkg.sv
// Shared frame limits, colour codes and the pixel record carried from the
// game datapath to the VGA write port.
package pixel_plot_queue_pkg;

  localparam int unsigned X_MAX = 160;
  localparam int unsigned Y_MAX = 120;
  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;

  localparam logic [CW-1:0] COL_BLACK = 3'b000;
  localparam logic [CW-1:0] COL_BLUE  = 3'b001;
  localparam logic [CW-1:0] COL_GREEN = 3'b010;
  localparam logic [CW-1:0] COL_RED   = 3'b100;
  localparam logic [CW-1:0] COL_WHITE = 3'b111;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo_mem.sv
// Pixel storage: DEPTH x pixel_t register array, synchronous write,
// asynchronous read at the read address.
module pixel_fifo_mem
  import pixel_plot_queue_pkg::pixel_t;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pixel_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output pixel_t        o_rdata
);

  pixel_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pixel_plot_queue.sv
// Pixel draw-request queue: clips off-frame requests, buffers the rest and
// feeds the VGA adapter one pixel per clock unless held.
module pixel_plot_queue
  import pixel_plot_queue_pkg::pixel_t;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned X_MAX = pixel_plot_queue_pkg::X_MAX,
  parameter int unsigned Y_MAX = pixel_plot_queue_pkg::Y_MAX
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_color,
  input  logic       flush,
  input  logic       hold,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       idle,
  output logic [7:0] dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [7:0]    r_vga_x;
  logic [6:0]    r_vga_y;
  logic [2:0]    r_vga_colour;
  logic          r_vga_plot;
  logic [7:0]    r_dropped;

  logic   w_empty;
  logic   w_full;
  logic   w_push;
  logic   w_in_frame;
  logic   w_store;
  logic   w_clip;
  logic   w_pop;
  pixel_t w_wdata;
  pixel_t w_head;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign in_ready   = !w_full && !flush;
  assign w_push     = in_valid && in_ready;
  assign w_in_frame = (32'(in_x) < X_MAX) && (32'(in_y) < Y_MAX);
  assign w_store    = w_push && w_in_frame;
  assign w_clip     = w_push && !w_in_frame;
  assign w_pop      = !w_empty && !hold && !flush;

  assign w_wdata = '{x: in_x, y: in_y, colour: in_color};

  pixel_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_head)
  );

  // Pointers; flush collapses the queue to empty.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + PW'(1);
      if (w_pop)   r_rptr <= r_rptr + PW'(1);
    end
  end

  // Output stage: coordinates hold their last value between plots.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_vga_plot <= w_pop;
      if (w_pop) begin
        r_vga_x      <= w_head.x;
        r_vga_y      <= w_head.y;
        r_vga_colour <= w_head.colour;
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_dropped <= '0;
    end else if (w_clip && (r_dropped != 8'hFF)) begin
      r_dropped <= r_dropped + 8'd1;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign dropped    = r_dropped;
  assign idle       = w_empty && !r_vga_plot;

endmodule

// File: tb/tb_pixel_plot_queue.sv
// Directed bench for pixel_plot_queue: latency, fill/hold, clipping,
// saturation, flush and asynchronous reset mid-stream.
module tb_pixel_plot_queue;
  import pixel_plot_queue_pkg::*;

  logic       clk;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_color;
  logic       flush;
  logic       hold;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       idle;
  logic [7:0] dropped;

  int unsigned n_cmp;
  int unsigned n_err;

  pixel_plot_queue #(.DEPTH(16), .X_MAX(160), .Y_MAX(120)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_color   (in_color),
    .flush      (flush),
    .hold       (hold),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .idle       (idle),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_color = c;
  endtask

  task automatic check_pix(input string tag, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    check({tag, ".plot"}, 32'(vga_plot), 32'd1);
    check({tag, ".x"}, 32'(vga_x), 32'(x));
    check({tag, ".y"}, 32'(vga_y), 32'(y));
    check({tag, ".col"}, 32'(vga_colour), 32'(c));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    resetn   = 1'b1;
    flush    = 1'b0;
    hold     = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    repeat (2) tick();
    resetn = 1'b0;

    // Reset state
    check("rst.ready", 32'(in_ready), 32'd1);
    check("rst.idle", 32'(idle), 32'd1);
    check("rst.plot", 32'(vga_plot), 32'd0);
    check("rst.dropped", 32'(dropped), 32'd0);
    check("rst.x", 32'(vga_x), 32'd0);
    tick();

    // Single pixel latency: handshake at edge N, plot after edge N+1
    drive(1'b1, 8'd10, 7'd20, COL_WHITE);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("lat.plot_n", 32'(vga_plot), 32'd0);
    check("lat.idle_n", 32'(idle), 32'd0);
    tick();
    check_pix("lat", 8'd10, 7'd20, COL_WHITE);
    tick();
    check("lat.plot_end", 32'(vga_plot), 32'd0);
    check("lat.idle_end", 32'(idle), 32'd1);

    // Fill 16 under hold, 17th refused, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i + 30), 7'(i + 1), 3'(i));
      check($sformatf("fill.ready%0d", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("fill.plot%0d", i), 32'(vga_plot), 32'd0);
    end
    check("fill.full", 32'(in_ready), 32'd0);
    drive(1'b1, 8'd99, 7'd99, COL_RED);
    tick();
    check("fill.still_full", 32'(in_ready), 32'd0);
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    hold = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_pix($sformatf("drain%0d", i), 8'(i + 30), 7'(i + 1), 3'(i));
    end
    tick();
    check("drain.plot_end", 32'(vga_plot), 32'd0);
    check("drain.idle", 32'(idle), 32'd1);

    // Clipping at the frame boundary
    drive(1'b1, 8'd160, 7'd5, COL_GREEN);
    tick();
    check("clip.x_plot", 32'(vga_plot), 32'd0);
    drive(1'b1, 8'd5, 7'd120, COL_GREEN);
    tick();
    check("clip.y_plot", 32'(vga_plot), 32'd0);
    check("clip.drop1", 32'(dropped), 32'd2);
    drive(1'b1, 8'd159, 7'd119, COL_GREEN);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("clip.drop2", 32'(dropped), 32'd2);
    check("clip.plot_n", 32'(vga_plot), 32'd0);
    tick();
    check_pix("clip.edge", 8'd159, 7'd119, COL_GREEN);
    tick();
    check("clip.plot_end", 32'(vga_plot), 32'd0);
    check("clip.idle", 32'(idle), 32'd1);

    // Saturation of the drop counter (starts at 2)
    drive(1'b1, 8'd200, 7'd10, COL_RED);
    for (int i = 0; i < 252; i++) tick();
    check("sat.254", 32'(dropped), 32'd254);
    tick();
    check("sat.255", 32'(dropped), 32'd255);
    for (int i = 0; i < 47; i++) tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("sat.hold255", 32'(dropped), 32'd255);
    check("sat.plot", 32'(vga_plot), 32'd0);
    check("sat.idle", 32'(idle), 32'd1);

    // Flush discards queued pixels and refuses the same-cycle push
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i + 50), 7'(i + 60), COL_BLUE);
      tick();
    end
    check("flush.idle_pre", 32'(idle), 32'd0);
    drive(1'b1, 8'd77, 7'd77, COL_RED);
    flush = 1'b1;
    #1;
    check("flush.ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("flush.idle", 32'(idle), 32'd1);
    check("flush.plot", 32'(vga_plot), 32'd0);
    tick();
    check("flush.plot2", 32'(vga_plot), 32'd0);
    check("flush.dropped", 32'(dropped), 32'd255);
    drive(1'b1, 8'd33, 7'd44, COL_GREEN);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    check("flush.post_n", 32'(vga_plot), 32'd0);
    tick();
    check_pix("flush.post", 8'd33, 7'd44, COL_GREEN);
    tick();
    check("flush.post_end", 32'(vga_plot), 32'd0);

    // Asynchronous reset in the middle of a 10-pixel stream
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(i + 100), 7'(i + 2), COL_RED);
      tick();
    end
    check("arst.plot_pre", 32'(vga_plot), 32'd1);
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    #2;
    resetn = 1'b1;
    #1;
    check("arst.plot", 32'(vga_plot), 32'd0);
    check("arst.idle", 32'(idle), 32'd1);
    check("arst.ready", 32'(in_ready), 32'd1);
    check("arst.x", 32'(vga_x), 32'd0);
    check("arst.dropped", 32'(dropped), 32'd0);
    tick();
    #2;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("arst.stale%0d", i), 32'(vga_plot), 32'd0);
    end
    drive(1'b1, 8'd1, 7'd2, COL_BLUE);
    tick();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    tick();
    check_pix("arst.post", 8'd1, 7'd2, COL_BLUE);
    tick();
    check("arst.idle_end", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_plot_queue.md
# pixel_plot_queue

Buffers pixel draw requests from the game datapath (dash, gallows, body-part and clear generators) and issues them one per clock to the VGA adapter's write port. Drops requests whose coordinates fall outside the 160x120 frame, paces output under a stall input, and reports when all queued pixels have been written. Sits directly downstream of the datapath's `qout`/`color` outputs and upstream of the VGA adapter.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..64.
- `X_MAX`, 160: first illegal x coordinate.
- `Y_MAX`, 120: first illegal y coordinate.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  queue can accept this cycle.
- `in_x`  in  8  pixel x.
- `in_y`  in  7  pixel y.
- `in_color`  in  3  pixel colour {R,G,B}.
- `flush`  in  1  synchronous discard of all queued pixels.
- `hold`  in  1  stall output stage; no pop while high.
- `vga_x`  out  8  registered x to adapter.
- `vga_y`  out  7  registered y to adapter.
- `vga_colour`  out  3  registered colour to adapter.
- `vga_plot`  out  1  adapter write enable, one-cycle per pixel.
- `idle`  out  1  queue empty and no write in flight.
- `dropped`  out  8  count of clipped requests, saturating.

## Operation
- Handshake: transfer when `in_valid && in_ready`. `in_ready = !full && !flush`.
- Clipping: transferred request with `in_x >= X_MAX` or `in_y >= Y_MAX` is consumed but not stored; `dropped` increments, saturates at 255.
- Storage: circular buffer, write/read pointers of log2(DEPTH)+1 bits; full when MSBs differ and low bits equal, empty when pointers equal. Occupancy never exceeds DEPTH.
- Pop: when `!empty && !hold && !flush`, head entry loads into `vga_x/vga_y/vga_colour` and `vga_plot` is set for the next cycle; otherwise `vga_plot` is cleared. Coordinates/colour hold last value when `vga_plot` low.
- Simultaneous push and pop on a full queue: push refused (`in_ready` low); pop proceeds. On an empty queue, a push is not visible to the pop logic until the following cycle (no bypass).
- `flush`: pointers reset to equal, `vga_plot` cleared next cycle, any push that cycle refused; `dropped` unaffected.
- `idle = empty && !vga_plot`.
- Reset (asserted any time, mid-burst included): pointers 0, `vga_plot` 0, `vga_x/vga_y/vga_colour` 0, `dropped` 0; hence `in_ready` 1, `idle` 1.

## Timing
- Latency: push accepted at edge N into empty queue -> `vga_plot` high during cycle after edge N+1 (2 clocks).
- Throughput: one pixel per clock sustained with `hold` low; a continuous stream never fills the queue.
- `hold` asserted in cycle C: no pop at end of C; `vga_plot` low in C+1. Release resumes pops at the next edge.
- `in_ready`, `idle` combinational from registered state and `flush` only; no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package: `X_MAX`, `Y_MAX` constants; colour constants `COL_BLACK=000`, `COL_BLUE=001`, `COL_GREEN=010`, `COL_RED=100`, `COL_WHITE=111`; 18-bit pixel record {x[7:0], y[6:0], colour[2:0]}.
- One sub-module: `pixel_fifo_mem` — DEPTH x 18 register array, synchronous write, asynchronous read at read pointer. Pointer, flag, clip and output-stage logic live in the top.

## Test plan
- Reset then push (10,20,111) with `hold` 0 -> `vga_plot` high exactly one cycle, 2 clocks after handshake, with x=10, y=20, colour=111; `idle` returns to 1 next cycle.
- `hold` 1, push 16 pixels, then a 17th -> `in_ready` 0 after 16th; release `hold` -> 16 pixels plotted in order on consecutive cycles.
- Push (160,5,010), (5,120,010), (159,119,010) -> `dropped`=2, only (159,119) plotted.
- Push 300 out-of-range requests -> `dropped` stops at 255.
- Queue 8 pixels with `hold` 1, pulse `flush` -> nothing plotted, `idle` 1 next cycle, subsequent push plots normally.
- Assert `resetn` mid-stream of 10 pixels -> `vga_plot` 0 immediately (asynchronous), queue empty, no stale pixel after release.
